r_slave_resp_buffer: RTL and testbench
======================================

Name: r_slave_resp_buffer

Overview:
Per-slave R-channel response buffer placed between each AXI slave's R port and the slave-side (sN_R*) inputs of the R-channel interconnect; one instance per slave port.
- Decouples slave R timing from the crossbar and the ordering controller with a DEPTH-entry FIFO.
- Optionally runs store-and-forward, presenting a burst downstream only once its RLAST beat is buffered. This keeps a slow slave from holding the arbitrated master R path mid-burst.

Parameters:
ID_width, 6, width of RID (matches slave-side ID width)
DATA_width, 32, width of RDATA
user_width, 1, width of RUSER
DEPTH, 8, FIFO entries; power of two, minimum 2
PTR_width, 3, log2(DEPTH)
SF_MODE, 0, 0 = cut-through, 1 = store-and-forward

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_RID  input  ID_width  slave RID
in_RDATA  input  DATA_width  slave RDATA
in_RRESP  input  2  slave RRESP
in_RLAST  input  1  slave RLAST
in_RUSER  input  user_width  slave RUSER
in_RVALID  input  1  slave RVALID
in_RREADY  output  1  ready to slave
out_RID  output  ID_width  to interconnect sN_RID
out_RDATA  output  DATA_width  to interconnect sN_RDATA
out_RRESP  output  2  to interconnect sN_RRESP
out_RLAST  output  1  to interconnect sN_RLAST
out_RUSER  output  user_width  to interconnect sN_RUSER
out_RVALID  output  1  to interconnect sN_RVALID
out_RREADY  input  1  from interconnect sN_RREADY
fill_count  output  PTR_width+1  beats currently stored
burst_count  output  PTR_width+1  RLAST beats currently stored

Behaviour:
Interface: one clock, clk; reset is synchronous and active-low on reset_n.
- Reset (reset_n=0 at a clk edge) clears wr_ptr, rd_ptr, fill_count and burst_count to 0 and sets the FSM to WAIT. While reset_n=0, in_RREADY=0 and out_RVALID=0. Reset mid-burst discards all stored beats; storage RAM is not cleared.
- Entry = {RID, RDATA, RRESP, RLAST, RUSER}.
- push = in_RVALID & in_RREADY; pop = out_RVALID & out_RREADY.
- in_RREADY = reset_n & (fill_count != DEPTH). It is a function of registered state only, with no combinational path from out_RREADY.
- out_R* payload = entry at rd_ptr, read combinationally from storage. It is don't-care when out_RVALID=0.
- Latency: a beat pushed at edge N is visible on out_R* with out_RVALID=1 after edge N in cut-through mode. There is no same-cycle in-to-out bypass; when empty, minimum latency is 1 cycle.
- Pointers increment modulo DEPTH on push and pop respectively; wrap from DEPTH-1 to 0.
- fill_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- burst_count: +1 on push of an RLAST=1 beat, -1 on pop of an RLAST=1 beat, unchanged if both happen in the same cycle.
- Full: in_RREADY=0 and no push. A pop in the same cycle frees an entry, but in_RREADY only rises the next cycle.
- Empty: out_RVALID=0 and no pop.
- SF_MODE=0: out_RVALID = (fill_count != 0). The FSM is unused.
- SF_MODE=1, FSM states WAIT and DRAIN:
  - WAIT: out_RVALID=0. Go to DRAIN when burst_count != 0, or when fill_count == DEPTH (overflow release for bursts longer than DEPTH; the burst then streams cut-through).
  - DRAIN: out_RVALID = (fill_count != 0). Return to WAIT on a pop of an RLAST=1 beat if the post-update burst_count == 0 and the FIFO is not full; otherwise stay in DRAIN.
- AXI rule: once out_RVALID=1, it and the payload stay stable until pop in both modes. DRAIN is exited only on a pop.
- No response reordering or ID modification; beats leave in arrival order.

Test Plan:
- Reset then idle, SF_MODE=0 -> in_RREADY=1, out_RVALID=0, fill_count=0, burst_count=0.
- SF_MODE=0: push a 4-beat burst, RID=6'h05, RDATA=1..4, out_RREADY=1 -> out beats 1..4 each one cycle after push; out_RLAST=1 only on beat 4; burst_count returns to 0.
- SF_MODE=0, DEPTH=8, out_RREADY=0: push 9 beats -> 8 accepted, in_RREADY=0 from the cycle after the 8th push, fill_count=8. Raise out_RREADY -> data 1..8 in order, pointers wrap, 9th beat accepted after the first pop.
- Simultaneous push+pop at fill_count=3, with and without RLAST on each side -> fill_count stays 3; burst_count tracks +1/-1/0 exactly.
- SF_MODE=1: push a 3-beat burst with a 2-cycle gap before the RLAST beat -> out_RVALID=0 until the cycle after the RLAST push, then 3 consecutive beats with out_RREADY=1.
- SF_MODE=1, DEPTH=8: push a 12-beat burst with out_RREADY=1 -> release at fill_count=8, all 12 beats delivered in order, FSM back in WAIT. Assert reset_n=0 mid-burst in a repeat -> next cycle fill_count=0, out_RVALID=0.

Source files
------------

// File: rtl/r_slave_resp_buffer.sv
// r_slave_resp_buffer: per-slave R-channel FIFO with optional store-and-forward burst release
module r_slave_resp_buffer #(
  parameter int ID_width   = 6,
  parameter int DATA_width = 32,
  parameter int user_width = 1,
  parameter int DEPTH      = 8,
  parameter int PTR_width  = 3,
  parameter int SF_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ID_width-1:0]   in_RID,
  input  logic [DATA_width-1:0] in_RDATA,
  input  logic [1:0]            in_RRESP,
  input  logic                  in_RLAST,
  input  logic [user_width-1:0] in_RUSER,
  input  logic                  in_RVALID,
  output logic                  in_RREADY,
  output logic [ID_width-1:0]   out_RID,
  output logic [DATA_width-1:0] out_RDATA,
  output logic [1:0]            out_RRESP,
  output logic                  out_RLAST,
  output logic [user_width-1:0] out_RUSER,
  output logic                  out_RVALID,
  input  logic                  out_RREADY,
  output logic [PTR_width:0]    fill_count,
  output logic [PTR_width:0]    burst_count
);
  localparam int EW = ID_width + DATA_width + 2 + 1 + user_width;
  localparam logic [PTR_width:0] FULL = (PTR_width+1)'(DEPTH);
  typedef enum logic {WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic [EW-1:0] mem [DEPTH];
  logic [PTR_width-1:0] wr_ptr, rd_ptr;
  logic [PTR_width:0] fill_n, burst_n;
  logic push, pop, last_in, last_out;
  assign in_RREADY = reset_n & (fill_count != FULL);
  assign out_RVALID = reset_n & (fill_count != '0) & (SF_MODE == 0 || state == DRAIN);
  assign {out_RID, out_RDATA, out_RRESP, out_RLAST, out_RUSER} = mem[rd_ptr];
  always_comb begin
    push = in_RVALID & in_RREADY;
    pop = out_RVALID & out_RREADY;
    last_in = push & in_RLAST;
    last_out = pop & out_RLAST;
    fill_n = fill_count + (PTR_width+1)'(push) - (PTR_width+1)'(pop);
    burst_n = burst_count + (PTR_width+1)'(last_in) - (PTR_width+1)'(last_out);
    state_n = state;
    // a full FIFO in WAIT releases an over-long burst so it can stream through
    if (state == WAIT)
      state_n = (burst_count != '0 || fill_count == FULL) ? DRAIN : WAIT;
    else if (last_out && burst_n == '0 && fill_n != FULL)
      state_n = WAIT;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_RID, in_RDATA, in_RRESP, in_RLAST, in_RUSER};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_count <= '0;
      burst_count <= '0;
      state <= WAIT;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fill_count <= fill_n;
      burst_count <= burst_n;
      state <= state_n;
    end
  end
endmodule

// File: tb/tb_r_slave_resp_buffer.sv
// tb_r_slave_resp_buffer: scoreboard plus vector-table bench for cut-through and store-and-forward instances
module tb_r_slave_resp_buffer;
  logic clk = 1'b0;
  logic rst_n, sel;
  logic [5:0] in_id;
  logic [31:0] in_data;
  logic [1:0] in_resp;
  logic in_last, in_user, in_valid, oready;
  logic rdy0, rdy1, v0, v1, l0, l1, u0, u1;
  logic [5:0] id0, id1;
  logic [31:0] d0, d1;
  logic [1:0] r0, r1;
  logic [3:0] f0, f1, b0, b1;
  logic rdy, valid, o_last, o_user;
  logic [5:0] o_id;
  logic [31:0] o_data;
  logic [1:0] o_resp;
  logic [3:0] fill, burst;
  int n_vec = 0, n_bad = 0;
  logic [41:0] q[$];
  always #5 clk = ~clk;

  r_slave_resp_buffer #(.SF_MODE(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .in_RID(in_id), .in_RDATA(in_data), .in_RRESP(in_resp),
    .in_RLAST(in_last), .in_RUSER(in_user), .in_RVALID(in_valid & ~sel), .in_RREADY(rdy0),
    .out_RID(id0), .out_RDATA(d0), .out_RRESP(r0), .out_RLAST(l0), .out_RUSER(u0),
    .out_RVALID(v0), .out_RREADY(oready & ~sel), .fill_count(f0), .burst_count(b0));
  r_slave_resp_buffer #(.SF_MODE(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .in_RID(in_id), .in_RDATA(in_data), .in_RRESP(in_resp),
    .in_RLAST(in_last), .in_RUSER(in_user), .in_RVALID(in_valid & sel), .in_RREADY(rdy1),
    .out_RID(id1), .out_RDATA(d1), .out_RRESP(r1), .out_RLAST(l1), .out_RUSER(u1),
    .out_RVALID(v1), .out_RREADY(oready & sel), .fill_count(f1), .burst_count(b1));

  assign rdy = sel ? rdy1 : rdy0;
  assign valid = sel ? v1 : v0;
  assign o_id = sel ? id1 : id0;
  assign o_data = sel ? d1 : d0;
  assign o_resp = sel ? r1 : r0;
  assign o_last = sel ? l1 : l0;
  assign o_user = sel ? u1 : u0;
  assign fill = sel ? f1 : f0;
  assign burst = sel ? b1 : b0;

  typedef struct {
    logic v, l, p;
    logic [3:0] fill, burst;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    oready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    in_resp = d[1:0];
    in_user = d[0];
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy) begin
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    for (int t = 0; t < 60 && fill != 0; t++) tick();
    chk("drain_fill", fill, 0);
  endtask

  // scoreboard: record accepted beats, compare every popped beat in order
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (in_valid && rdy) q.push_back({in_id, in_data, in_resp, in_last, in_user});
      if (valid && oready) begin
        if (q.size() == 0) chk("pop_empty_sb", 1, 0);
        else chk("beat", {o_id, o_data, o_resp, o_last, o_user}, q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0, 1, 3, 1};
    tbl[1] = '{1, 1, 1, 3, 2};
    tbl[2] = '{1, 1, 1, 3, 2};
    tbl[3] = '{1, 0, 1, 3, 2};
    tbl[4] = '{1, 0, 1, 3, 1};
    tbl[5] = '{0, 0, 1, 2, 0};
    tbl[6] = '{1, 1, 0, 3, 1};
    sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; oready = 1'b0;
    in_id = 6'h05; in_data = '0; in_resp = '0; in_last = 1'b0; in_user = 1'b0;
    tick();
    chk("rst_rdy", rdy, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", rdy, 1);
    chk("idle_valid", valid, 0);
    chk("idle_fill", fill, 0);
    chk("idle_burst", burst, 0);

    oready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(i, i == 4);
      chk("ct_valid", valid, 1);
      chk("ct_data", o_data, i);
      chk("ct_last", o_last, i == 4);
    end
    tick();
    chk("ct_after_valid", valid, 0);
    chk("ct_after_burst", burst, 0);

    do_reset();
    for (int i = 1; i <= 8; i++) send(i, i == 8);
    chk("full_fill", fill, 8);
    chk("full_rdy", rdy, 0);
    in_valid = 1'b1; in_data = 9; in_last = 1'b1; in_resp = 2'd1; in_user = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("full_hold", fill, 8);
    end
    oready = 1'b1;
    send(9, 1);
    chk("full_refill", fill, 7);
    wait_empty();
    chk("full_burst", burst, 0);

    do_reset();
    send(1, 1);
    send(2, 0);
    send(3, 1);
    chk("pp_fill0", fill, 3);
    chk("pp_burst0", burst, 2);
    for (int r = 0; r < 7; r++) begin
      in_valid = tbl[r].v; in_last = tbl[r].l; oready = tbl[r].p;
      in_data = 100 + r; in_resp = 2'(r); in_user = r[0];
      tick();
      in_valid = 1'b0; oready = 1'b0;
      chk("pp_fill", fill, tbl[r].fill);
      chk("pp_burst", burst, tbl[r].burst);
    end
    oready = 1'b1;
    wait_empty();

    sel = 1'b1;
    do_reset();
    oready = 1'b1;
    chk("sf_idle_rdy", rdy, 1);
    send(1, 0);
    chk("sf_gap_valid0", valid, 0);
    send(2, 0);
    tick();
    chk("sf_gap_valid1", valid, 0);
    tick();
    chk("sf_gap_valid2", valid, 0);
    send(3, 1);
    for (int t = 0; t < 4 && !valid; t++) tick();
    for (int k = 0; k < 3; k++) begin
      chk("sf_stream_valid", valid, 1);
      tick();
    end
    chk("sf_done_valid", valid, 0);
    chk("sf_done_fill", fill, 0);

    do_reset();
    oready = 1'b1;
    for (int i = 1; i <= 8; i++) send(i, 0);
    chk("sf_ovf_fill", fill, 8);
    chk("sf_ovf_held", valid, 0);
    for (int i = 9; i <= 12; i++) send(i, i == 12);
    wait_empty();
    chk("sf_ovf_burst", burst, 0);
    send(13, 0);
    tick();
    tick();
    chk("sf_back_wait", valid, 0);
    chk("sf_back_fill", fill, 1);
    rst_n = 1'b0;
    tick();
    chk("sf_rst_fill", fill, 0);
    chk("sf_rst_valid", valid, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) send(i, 0);
    rst_n = 1'b0;
    tick();
    chk("sf_rst2_fill", fill, 0);
    chk("sf_rst2_valid", valid, 0);
    chk("sf_rst2_rdy", rdy, 0);
    rst_n = 1'b1;
    tick();
    chk("sf_rst2_rdy_up", rdy, 1);
    chk("sf_rst2_burst", burst, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
